// File: rtl/wide_alu_seq_pkg.sv
// Shared encodings for wide_alu_seq: operation / ALU-select codes, FSM states
// and the signed-overflow helper used when WIDE_ALU_OVF_EN is defined.
package wide_alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_PASS = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ZERO = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [7:0] ALU_IDLE_OPND = 8'h00;
  localparam logic [7:0] FIX_ONE       = 8'h01;
  localparam logic [7:0] FIX_MSB       = 8'h80;

  // Signed 16-bit overflow from the operand and result sign bits.
  function automatic logic signed_ovf(input op_e op, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic ovf;
    case (op)
      OP_ADD:  ovf = (a_msb == b_msb) && (r_msb != a_msb);
      OP_SUB:  ovf = (a_msb != b_msb) && (r_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage

// File: rtl/wide_alu_seq_if.sv
// Request/result and external 8-bit ALU signals of wide_alu_seq.
// WIDE_ALU_OVF_EN adds the registered signed-overflow flag 'over'.
interface wide_alu_seq_if;

  logic        start;
  logic [2:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic        neg;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
`ifdef WIDE_ALU_OVF_EN
  logic        over;
`endif

  modport slave (
    input  start, op, opa, opb, alu_out, alu_carry,
    output busy, done, result, carry, zero, neg, alu_a, alu_b, alu_sel
`ifdef WIDE_ALU_OVF_EN
    , output over
`endif
  );

  modport master (
    output start, op, opa, opb, alu_out, alu_carry,
    input  busy, done, result, carry, zero, neg, alu_a, alu_b, alu_sel
`ifdef WIDE_ALU_OVF_EN
    , input over
`endif
  );

endinterface

// File: rtl/wide_alu_seq.sv
// 16-bit sequential ALU built from byte passes through an external 8-bit ALU.
// Optional feature macro: WIDE_ALU_OVF_EN (adds registered 'over' flag).
module wide_alu_seq
  import wide_alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  wide_alu_seq_if.slave bus
);

  state_e      r_state;
  op_e         r_op;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [7:0]  r_first;
  logic        r_first_carry;
  logic        r_second_carry;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_result;
  logic        r_carry;
  logic        r_zero;
  logic        r_neg;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [2:0]  r_alu_sel;
`ifdef WIDE_ALU_OVF_EN
  logic        r_over;
`endif

  op_e         w_op_in;
  logic        w_fix_req;
  op_e         w_fix_sel;
  logic [7:0]  w_fix_b;
  logic        w_carry;
  logic        w_finish;
  logic [15:0] w_result;

  assign w_op_in = op_e'(bus.op);

  // Fix-up decision, result assembly and carry for the pass that closes an op.
  // The fix-up always patches the second pass byte, which for SHR is the low byte.
  always_comb begin
    w_fix_req = 1'b0;
    w_fix_sel = OP_OR;
    w_fix_b   = FIX_ONE;
    w_carry   = 1'b0;
    w_result  = (r_op == OP_SHR) ? {r_first, bus.alu_out} : {bus.alu_out, r_first};
    case (r_op)
      OP_ADD: begin
        w_fix_req = r_first_carry;
        w_fix_sel = OP_ADD;
        w_carry   = (r_state == ST_FIX) ? (r_second_carry | bus.alu_carry) : bus.alu_carry;
      end
      OP_SUB: begin
        w_fix_req = (r_opa[7:0] < r_opb[7:0]);
        w_fix_sel = OP_SUB;
        w_carry   = (r_opa < r_opb);
      end
      OP_SHL: begin
        w_fix_req = r_opa[7];
        w_carry   = r_opa[15];
      end
      OP_SHR: begin
        w_fix_req = r_opa[8];
        w_fix_b   = FIX_MSB;
        w_carry   = r_opa[0];
      end
      default: begin
        w_fix_req = 1'b0;
        w_carry   = 1'b0;
      end
    endcase
    w_finish = ((r_state == ST_HI) && !w_fix_req) || (r_state == ST_FIX);
  end

  // Sequencer: state, operand capture, busy and the registered ALU drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_ZERO;
      r_opa          <= 16'h0000;
      r_opb          <= 16'h0000;
      r_first        <= 8'h00;
      r_first_carry  <= 1'b0;
      r_second_carry <= 1'b0;
      r_busy         <= 1'b0;
      r_alu_a        <= ALU_IDLE_OPND;
      r_alu_b        <= ALU_IDLE_OPND;
      r_alu_sel      <= OP_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_LO;
            r_busy    <= 1'b1;
            r_op      <= w_op_in;
            r_opa     <= bus.opa;
            r_opb     <= bus.opb;
            r_alu_sel <= bus.op;
            // SHR needs the high byte first so its bit 0 can be folded into the low byte.
            if (w_op_in == OP_SHR) begin
              r_alu_a <= bus.opa[15:8];
              r_alu_b <= bus.opb[15:8];
            end else begin
              r_alu_a <= bus.opa[7:0];
              r_alu_b <= bus.opb[7:0];
            end
          end
        end
        ST_LO: begin
          r_first       <= bus.alu_out;
          r_first_carry <= bus.alu_carry;
          r_state       <= ST_HI;
          if (r_op == OP_SHR) begin
            r_alu_a <= r_opa[7:0];
            r_alu_b <= r_opb[7:0];
          end else begin
            r_alu_a <= r_opa[15:8];
            r_alu_b <= r_opb[15:8];
          end
        end
        ST_HI: begin
          r_second_carry <= bus.alu_carry;
          if (w_fix_req) begin
            r_state   <= ST_FIX;
            r_alu_sel <= w_fix_sel;
            r_alu_a   <= bus.alu_out;
            r_alu_b   <= w_fix_b;
          end else begin
            r_state   <= ST_DONE;
            r_alu_sel <= OP_ZERO;
            r_alu_a   <= ALU_IDLE_OPND;
            r_alu_b   <= ALU_IDLE_OPND;
          end
        end
        ST_FIX: begin
          r_state   <= ST_DONE;
          r_alu_sel <= OP_ZERO;
          r_alu_a   <= ALU_IDLE_OPND;
          r_alu_b   <= ALU_IDLE_OPND;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_alu_sel <= OP_ZERO;
          r_alu_a   <= ALU_IDLE_OPND;
          r_alu_b   <= ALU_IDLE_OPND;
        end
      endcase
    end
  end

  // Result and flag registers, loaded on the pass that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_result <= 16'h0000;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
`ifdef WIDE_ALU_OVF_EN
      r_over   <= 1'b0;
`endif
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= w_result;
        r_carry  <= w_carry;
        r_zero   <= (w_result == 16'h0000);
        r_neg    <= w_result[15];
`ifdef WIDE_ALU_OVF_EN
        r_over   <= signed_ovf(r_op, r_opa[15], r_opb[15], w_result[15]);
`endif
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.carry   = r_carry;
  assign bus.zero    = r_zero;
  assign bus.neg     = r_neg;
  assign bus.alu_a   = r_alu_a;
  assign bus.alu_b   = r_alu_b;
  assign bus.alu_sel = r_alu_sel;
`ifdef WIDE_ALU_OVF_EN
  assign bus.over    = r_over;
`endif

endmodule

// File: tb/tb_wide_alu_seq.sv
// Self-checking bench for wide_alu_seq: external 8-bit ALU model, 16-bit
// reference model with per-cycle compare, plus directed literal vectors.
module tb_wide_alu_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  wide_alu_seq_if bus_if ();

  wide_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 8-bit ALU
  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'h000;
    case (bus_if.alu_sel)
      3'b000:  alu_t = {1'b0, bus_if.alu_a} + {1'b0, bus_if.alu_b};
      3'b001:  alu_t = {1'b0, bus_if.alu_a} - {1'b0, bus_if.alu_b};
      3'b010:  alu_t = {1'b0, bus_if.alu_a & bus_if.alu_b};
      3'b011:  alu_t = {1'b0, bus_if.alu_a | bus_if.alu_b};
      3'b100:  alu_t = {1'b0, bus_if.alu_a};
      3'b101:  alu_t = {bus_if.alu_a, 1'b0};
      3'b110:  alu_t = {2'b00, bus_if.alu_a[7:1]};
      default: alu_t = 9'h000;
    endcase
  end
  assign bus_if.alu_out   = alu_t[7:0];
  assign bus_if.alu_carry = alu_t[8];

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        ov;
    logic [2:0]  lat;
  } exp_t;

  // 16-bit reference: result, carry, signed overflow and start-to-done latency
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    int sa;
    int sb;
    int sr;
    sa = $signed(a);
    sb = $signed(b);
    e.res = 16'h0000; e.c = 1'b0; e.ov = 1'b0; e.lat = 3'd3;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[15:0]; e.c = s[16];
        sr = sa + sb; e.ov = (sr > 32767) || (sr < -32768);
        e.lat = (({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255) ? 3'd4 : 3'd3;
      end
      3'b001: begin
        e.res = a - b; e.c = (a < b);
        sr = sa - sb; e.ov = (sr > 32767) || (sr < -32768);
        e.lat = (a[7:0] < b[7:0]) ? 3'd4 : 3'd3;
      end
      3'b010:  e.res = a & b;
      3'b011:  e.res = a | b;
      3'b100:  e.res = a;
      3'b101: begin e.res = a << 1; e.c = a[15]; e.lat = a[7] ? 3'd4 : 3'd3; end
      3'b110: begin e.res = a >> 1; e.c = a[0];  e.lat = a[8] ? 3'd4 : 3'd3; end
      default: e.res = 16'h0000;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: remaining cycles of the in-flight op and visible outputs
  int          m_cnt;
  int          m_lat;
  logic [2:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_b;
  exp_t        m_p;
  logic [15:0] m_res;
  logic        m_c, m_z, m_n, m_ov;
  exp_t        w_acc;
  assign w_acc = model(bus_if.op, bus_if.opa, bus_if.opb);

  initial begin
    m_cnt = 0; m_lat = 0; m_op = 3'd0; m_a = 16'h0; m_b = 16'h0; m_p = '0;
    m_res = 16'h0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_ov = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_res <= 16'h0000; m_c <= 1'b0; m_z <= 1'b0; m_n <= 1'b0; m_ov <= 1'b0;
    end else if (m_cnt == 0) begin
      if (bus_if.start) begin
        m_p   <= w_acc;
        m_cnt <= int'(w_acc.lat);
        m_lat <= int'(w_acc.lat);
        m_op  <= bus_if.op;
        m_a   <= bus_if.opa;
        m_b   <= bus_if.opb;
      end
    end else begin
      if (m_cnt == 2) begin
        m_res <= m_p.res; m_c <= m_p.c; m_ov <= m_p.ov;
        m_z   <= (m_p.res == 16'h0000); m_n <= m_p.res[15];
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("busy",   {15'd0, bus_if.busy},  {15'd0, (m_cnt != 0)});
    chk("done",   {15'd0, bus_if.done},  {15'd0, (m_cnt == 1)});
    chk("result", bus_if.result, m_res);
    chk("carry",  {15'd0, bus_if.carry}, {15'd0, m_c});
    chk("zero",   {15'd0, bus_if.zero},  {15'd0, m_z});
    chk("neg",    {15'd0, bus_if.neg},   {15'd0, m_n});
`ifdef WIDE_ALU_OVF_EN
    chk("over",   {15'd0, bus_if.over},  {15'd0, m_ov});
`endif
    if (m_cnt <= 1) begin
      chk("idle_sel", {13'd0, bus_if.alu_sel}, 16'h0007);
      chk("idle_a",   {8'd0, bus_if.alu_a},    16'h0000);
      chk("idle_b",   {8'd0, bus_if.alu_b},    16'h0000);
    end else if (m_cnt == m_lat) begin
      chk("p1_sel", {13'd0, bus_if.alu_sel}, {13'd0, m_op});
      chk("p1_a", {8'd0, bus_if.alu_a}, {8'd0, (m_op == 3'b110) ? m_a[15:8] : m_a[7:0]});
      chk("p1_b", {8'd0, bus_if.alu_b}, {8'd0, (m_op == 3'b110) ? m_b[15:8] : m_b[7:0]});
    end else if (m_cnt == m_lat - 1) begin
      chk("p2_sel", {13'd0, bus_if.alu_sel}, {13'd0, m_op});
      chk("p2_a", {8'd0, bus_if.alu_a}, {8'd0, (m_op == 3'b110) ? m_a[7:0] : m_a[15:8]});
      chk("p2_b", {8'd0, bus_if.alu_b}, {8'd0, (m_op == 3'b110) ? m_b[7:0] : m_b[15:8]});
    end else begin
      chk("fix_sel", {13'd0, bus_if.alu_sel},
          {13'd0, (m_op == 3'b000) ? 3'b000 : ((m_op == 3'b001) ? 3'b001 : 3'b011)});
      chk("fix_b", {8'd0, bus_if.alu_b}, {8'd0, (m_op == 3'b110) ? 8'h80 : 8'h01});
    end
  end

  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] e_res, input logic e_c,
                        input logic e_z, input logic e_n, input logic e_ov,
                        input int e_lat, input bit dup);
    int k;
    bit seen;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = o; bus_if.opa = a; bus_if.opb = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 8) begin
      if (bus_if.done) begin
        seen = 1'b1;
      end else begin
        if (dup && k == 1) begin
          bus_if.start = 1'b1; bus_if.op = 3'b000; bus_if.opa = 16'hFFFF; bus_if.opb = 16'hFFFF;
        end
        if (k == 2) bus_if.start = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    bus_if.start = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: done not seen within 8 cycles", tag);
    end else begin
      chk({tag, "_lat"},   16'(k), 16'(e_lat));
      chk({tag, "_res"},   bus_if.result, e_res);
      chk({tag, "_carry"}, {15'd0, bus_if.carry}, {15'd0, e_c});
      chk({tag, "_zero"},  {15'd0, bus_if.zero},  {15'd0, e_z});
      chk({tag, "_neg"},   {15'd0, bus_if.neg},   {15'd0, e_n});
`ifdef WIDE_ALU_OVF_EN
      chk({tag, "_over"},  {15'd0, bus_if.over},  {15'd0, e_ov});
`endif
      chk({tag, "_model_res"}, m_res, e_res);
      chk({tag, "_model_c"},   {15'd0, m_c}, {15'd0, e_c});
      chk({tag, "_model_ov"},  {15'd0, m_ov}, {15'd0, e_ov});
      chk({tag, "_model_lat"}, 16'(m_lat), 16'(e_lat));
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus_if.start = 1'b0; bus_if.op = 3'b000; bus_if.opa = 16'h0000; bus_if.opb = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {15'd0, bus_if.busy},   16'h0000);
    chk("rst_done",   {15'd0, bus_if.done},   16'h0000);
    chk("rst_result", bus_if.result,          16'h0000);
    chk("rst_sel",    {13'd0, bus_if.alu_sel}, 16'h0007);
    rst_n = 1'b1;

    //      tag    op      opa       opb       result   c     z     n     ov    lat dup
    run_op("add1", 3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    run_op("add2", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    run_op("sub1", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    run_op("sub2", 3'b001, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    run_op("shl1", 3'b101, 16'h4080, 16'h0000, 16'h8100, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    run_op("shr1", 3'b110, 16'h0101, 16'h0000, 16'h0080, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    run_op("and1", 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    run_op("add3", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    run_op("or1",  3'b011, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_op("pas1", 3'b100, 16'hABCD, 16'hFFFF, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    run_op("zro1", 3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    run_op("add4", 3'b000, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_op("sub3", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    run_op("shr2", 3'b110, 16'h8001, 16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_op("shl2", 3'b101, 16'h0001, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_op("add5", 3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0);

    // Reset asserted while the HI pass is in flight
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 3'b000; bus_if.opa = 16'h00FF; bus_if.opb = 16'h0001;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy",   {15'd0, bus_if.busy},  16'h0000);
    chk("abort_result", bus_if.result,         16'h0000);
    chk("abort_carry",  {15'd0, bus_if.carry}, 16'h0000);
    chk("abort_zero",   {15'd0, bus_if.zero},  16'h0000);
    chk("abort_neg",    {15'd0, bus_if.neg},   16'h0000);
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", {15'd0, bus_if.done}, 16'h0000);
      @(negedge clk);
    end
    run_op("post", 3'b000, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
